simon_frame_loader: RTL and testbench



---
 rtl/simon_frame_loader_pkg.sv | 32 +++
 rtl/simon_frame_loader_if.sv | 31 +++
 rtl/frame_timeout_timer.sv | 44 ++++
 rtl/simon_frame_loader.sv | 141 ++++++++++++++
 tb/tb_simon_frame_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_frame_loader_pkg.sv
// Shared definitions for the Simon 32/64 frame loader and the cipher core it feeds.
// Contents:
//   CMD_*_BYTE      default command byte values for the framing protocol
//   TEXT_BYTES      payload length of a text frame (32-bit word)
//   KEY_BYTES       payload length of a key frame (64-bit key)
//   state_e         loader FSM state encoding (3 bits)
//   last_payload_byte() true when the byte now being accepted completes the frame
package simon_frame_loader_pkg;

    localparam logic [7:0] CMD_TEXT_BYTE  = 8'h50;  // 'P'
    localparam logic [7:0] CMD_KEY_BYTE   = 8'h4B;  // 'K'
    localparam logic [7:0] CMD_START_BYTE = 8'h53;  // 'S'

    localparam int TEXT_BYTES = 4;
    localparam int KEY_BYTES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_TEXT = 3'd1,
        ST_RX_KEY  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_START   = 3'd5
    } state_e;

    // cnt is the number of payload bytes already accepted in this frame.
    function automatic logic last_payload_byte(input state_e st, input logic [3:0] cnt);
        return ((st == ST_RX_TEXT) && (cnt == 4'(TEXT_BYTES - 1))) ||
               ((st == ST_RX_KEY)  && (cnt == 4'(KEY_BYTES - 1)));
    endfunction

endpackage

// File: rtl/simon_frame_loader_if.sv
// Byte-stream input and cipher-core output bundle of the frame loader.
// Signals:
//   rx_data/rx_valid  byte strobe from the UART receiver
//   plntxt/key        assembled buses to the core
//   load_plntxt/load_key/start_cipher  one-cycle strobes to the core
//   busy              frame in progress or commit pending
//   frame_err         one-cycle strobe on unknown command or timeout
// Modports: master = the loader itself, slave = its environment.
interface simon_frame_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] plntxt;
    logic [63:0] key;
    logic        load_plntxt;
    logic        load_key;
    logic        start_cipher;
    logic        busy;
    logic        frame_err;

    modport master (
        input  rx_data, rx_valid,
        output plntxt, key, load_plntxt, load_key, start_cipher, busy, frame_err
    );

    modport slave (
        output rx_data, rx_valid,
        input  plntxt, key, load_plntxt, load_key, start_cipher, busy, frame_err
    );

endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer for the frame loader.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear_i      restart the count from zero (wins over enable_i)
//   enable_i     count one idle clock
//   expired_o    high while enabled and TIMEOUT_CYCLES-1 idle clocks have elapsed
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/simon_frame_loader.sv
// Assembles 'P' (text), 'K' (key) and 'S' (start) command frames from a UART byte stream
// and drives the Simon 32/64 core's plntxt/key buses and load/start strobes.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        simon_frame_loader_if.master: rx_data/rx_valid in; plntxt, key,
//              load_plntxt, load_key, start_cipher, busy, frame_err out
// A completed payload is written to its bus on the accepting edge; the matching load
// strobe follows two clocks later, giving the core's capture register one clear cycle.
module simon_frame_loader
    import simon_frame_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0] CMD_TEXT       = CMD_TEXT_BYTE,
    parameter logic [7:0] CMD_KEY        = CMD_KEY_BYTE,
    parameter logic [7:0] CMD_START      = CMD_START_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    simon_frame_loader_if.master  bus
);

    state_e      state_q;
    logic [3:0]  byte_cnt_q;
    logic        is_key_q;       // frame type carried through HOLD/COMMIT
    logic [55:0] shift_q;        // the last payload byte never needs storing here
    logic [31:0] plntxt_q;
    logic [63:0] key_q;
    logic        load_plntxt_q;
    logic        load_key_q;
    logic        start_cipher_q;
    logic        frame_err_q;

    logic in_rx;
    logic timer_clear;
    logic timer_expired;

    assign in_rx       = (state_q == ST_RX_TEXT) || (state_q == ST_RX_KEY);
    // Outside the payload states the timer is held at zero, so a new frame starts fresh.
    assign timer_clear = !in_rx || bus.rx_valid;

    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .enable_i  (in_rx),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            is_key_q       <= 1'b0;
            shift_q        <= '0;
            plntxt_q       <= '0;
            key_q          <= '0;
            load_plntxt_q  <= 1'b0;
            load_key_q     <= 1'b0;
            start_cipher_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            load_plntxt_q  <= 1'b0;
            load_key_q     <= 1'b0;
            start_cipher_q <= 1'b0;
            frame_err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        byte_cnt_q <= '0;
                        if (bus.rx_data == CMD_TEXT) begin
                            state_q  <= ST_RX_TEXT;
                            is_key_q <= 1'b0;
                        end else if (bus.rx_data == CMD_KEY) begin
                            state_q  <= ST_RX_KEY;
                            is_key_q <= 1'b1;
                        end else if (bus.rx_data == CMD_START) begin
                            state_q <= ST_START;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end

                ST_RX_TEXT, ST_RX_KEY: begin
                    // Timeout takes priority over a byte arriving on the same cycle.
                    if (timer_expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (bus.rx_valid) begin
                        shift_q <= {shift_q[47:0], bus.rx_data};
                        if (byte_cnt_q != 4'hF) begin
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                        end
                        if (last_payload_byte(state_q, byte_cnt_q)) begin
                            if (state_q == ST_RX_TEXT) begin
                                plntxt_q <= {shift_q[23:0], bus.rx_data};
                            end else begin
                                key_q <= {shift_q, bus.rx_data};
                            end
                            state_q <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    state_q <= ST_COMMIT;
                end

                ST_COMMIT: begin
                    if (is_key_q) begin
                        load_key_q <= 1'b1;
                    end else begin
                        load_plntxt_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                ST_START: begin
                    start_cipher_q <= 1'b1;
                    state_q        <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.plntxt       = plntxt_q;
    assign bus.key          = key_q;
    assign bus.load_plntxt  = load_plntxt_q;
    assign bus.load_key     = load_key_q;
    assign bus.start_cipher = start_cipher_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simon_frame_loader.sv
// Self-checking bench for simon_frame_loader: directed frame table, multi-cycle corner
// sequences (latency, dropped bytes, timeout, reset mid-frame) and randomized frames
// compared against a transaction-level model of the framing rules.
module tb_simon_frame_loader;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simon_frame_loader_if bus ();

    simon_frame_loader #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Cycle counter and strobe monitor.
    int cyc = 0;
    int n_lp = 0, n_lk = 0, n_st = 0, n_err = 0;
    int lp_cyc = 0, lk_cyc = 0, st_cyc = 0, err_cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.load_plntxt === 1'b1)  begin n_lp++;  lp_cyc  = cyc; end
        if (bus.load_key === 1'b1)     begin n_lk++;  lk_cyc  = cyc; end
        if (bus.start_cipher === 1'b1) begin n_st++;  st_cyc  = cyc; end
        if (bus.frame_err === 1'b1)    begin n_err++; err_cyc = cyc; end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [0:8][7:0] b;
        int              n;
        logic [31:0]     p;
        logic [63:0]     k;
        int              lp, lk, st, err;
    } vec_t;

    vec_t vecs[5];

    // Reference model state: last committed buses.
    logic [31:0] p_m;
    logic [63:0] k_m;

    initial begin
        int b_lp, b_lk, b_st, b_err, last;
        logic [63:0] v;
        logic [7:0]  b;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        vecs[0] = '{b: {8'h50, 8'h65, 8'h65, 8'h68, 8'h77, 32'h0}, n: 5,
                    p: 32'h6565_6877, k: 64'h0, lp: 1, lk: 0, st: 0, err: 0};
        vecs[1] = '{b: {8'h4B, 8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00}, n: 9,
                    p: 32'h6565_6877, k: 64'h1918_1110_0908_0100, lp: 0, lk: 1, st: 0, err: 0};
        vecs[2] = '{b: {8'h53, 64'h0}, n: 1,
                    p: 32'h6565_6877, k: 64'h1918_1110_0908_0100, lp: 0, lk: 0, st: 1, err: 0};
        vecs[3] = '{b: {8'h7A, 64'h0}, n: 1,
                    p: 32'h6565_6877, k: 64'h1918_1110_0908_0100, lp: 0, lk: 0, st: 0, err: 1};
        vecs[4] = '{b: {8'h50, 32'hDEAD_BEEF, 32'h0}, n: 5,
                    p: 32'hDEAD_BEEF, k: 64'h1918_1110_0908_0100, lp: 1, lk: 0, st: 0, err: 0};

        // Reset state.
        idle(2);
        check("rst_plntxt", 64'(bus.plntxt), 64'h0);
        check("rst_key", bus.key, 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_strobes", 64'({bus.load_plntxt, bus.load_key, bus.start_cipher, bus.frame_err}), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed frame table.
        for (int i = 0; i < 5; i++) begin
            b_lp = n_lp; b_lk = n_lk; b_st = n_st; b_err = n_err;
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            if (vecs[i].err != 0) check($sformatf("v%0d_busy_after_err", i), 64'(bus.busy), 64'h0);
            idle(6);
            check($sformatf("v%0d_lp", i),  64'(n_lp - b_lp),   64'(vecs[i].lp));
            check($sformatf("v%0d_lk", i),  64'(n_lk - b_lk),   64'(vecs[i].lk));
            check($sformatf("v%0d_st", i),  64'(n_st - b_st),   64'(vecs[i].st));
            check($sformatf("v%0d_err", i), 64'(n_err - b_err), 64'(vecs[i].err));
            check($sformatf("v%0d_plntxt", i), 64'(bus.plntxt), 64'(vecs[i].p));
            check($sformatf("v%0d_key", i), bus.key, vecs[i].k);
            check($sformatf("v%0d_busy", i), 64'(bus.busy), 64'h0);
        end
        p_m = 32'hDEAD_BEEF;
        k_m = 64'h1918_1110_0908_0100;

        // Key latency, bus valid on accepting edge, stray byte during HOLD dropped silently.
        @(negedge clk);
        b_lp = n_lp; b_lk = n_lk; b_err = n_err;
        send_byte(8'h4B);
        for (int j = 1; j <= 8; j++) send_byte(8'(j));
        last = acc_cyc;
        check("hold_busy", 64'(bus.busy), 64'h1);
        check("hold_key_early", bus.key, 64'h0102_0304_0506_0708);
        send_byte(8'h7A);
        idle(6);
        check("lat_key_count", 64'(n_lk - b_lk), 64'h1);
        check("lat_key_cycles", 64'(lk_cyc - last), 64'h2);
        check("hold_drop_err", 64'(n_err - b_err), 64'h0);
        check("hold_drop_lp", 64'(n_lp - b_lp), 64'h0);
        k_m = 64'h0102_0304_0506_0708;

        // Start latency.
        @(negedge clk);
        b_lp = n_lp; b_lk = n_lk; b_st = n_st;
        send_byte(8'h53);
        last = acc_cyc;
        idle(4);
        check("start_count", 64'(n_st - b_st), 64'h1);
        check("start_cycles", 64'(st_cyc - last), 64'h1);
        check("start_no_load", 64'((n_lp - b_lp) + (n_lk - b_lk)), 64'h0);

        // Timeout: partial text frame then silence.
        @(negedge clk);
        b_lp = n_lp; b_err = n_err;
        send_byte(8'h50); send_byte(8'hAA); send_byte(8'hBB);
        last = acc_cyc;
        for (int w = 0; w < 40 && n_err == b_err; w++) idle(1);
        check("to_err_count", 64'(n_err - b_err), 64'h1);
        check("to_err_cycles", 64'(err_cyc - last), 64'(TO));
        idle(2);
        check("to_no_load", 64'(n_lp - b_lp), 64'h0);
        check("to_plntxt_kept", 64'(bus.plntxt), 64'(p_m));
        check("to_busy", 64'(bus.busy), 64'h0);

        // Byte arriving on the expiring cycle is dropped; loader is idle and usable afterwards.
        @(negedge clk);
        b_lp = n_lp; b_err = n_err; b_st = n_st;
        send_byte(8'h50); send_byte(8'hAA);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h11);
        idle(3);
        check("race_err_count", 64'(n_err - b_err), 64'h1);
        check("race_busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        send_byte(8'h53);
        idle(4);
        check("race_then_start", 64'(n_st - b_st), 64'h1);
        check("race_no_load", 64'(n_lp - b_lp), 64'h0);

        // Reset after the 6th key byte.
        @(negedge clk);
        send_byte(8'h4B);
        for (int j = 0; j < 6; j++) send_byte(8'hC0 + 8'(j));
        b_lp = n_lp; b_lk = n_lk; b_st = n_st; b_err = n_err;
        rst = 1'b1;
        #1;
        check("midrst_key", bus.key, 64'h0);
        check("midrst_plntxt", 64'(bus.plntxt), 64'h0);
        check("midrst_busy", 64'(bus.busy), 64'h0);
        idle(3);
        rst = 1'b0;
        idle(3);
        check("midrst_strobes", 64'((n_lp - b_lp) + (n_lk - b_lk) + (n_st - b_st) + (n_err - b_err)), 64'h0);
        p_m = 32'h0;
        @(negedge clk);
        send_byte(8'h4B);
        for (int j = 0; j < 8; j++) send_byte(8'h10 * 8'(j) + 8'h0F);
        idle(6);
        check("midrst_reload_key", bus.key, 64'h0F1F_2F3F_4F5F_6F7F);
        check("midrst_reload_lk", 64'(n_lk - b_lk), 64'h1);
        k_m = 64'h0F1F_2F3F_4F5F_6F7F;

        // Randomized frames against the transaction-level model.
        for (int it = 0; it < 40; it++) begin
            int kind, n, nsend, gap;
            bit abort;
            int e_lp, e_lk, e_st, e_err;
            @(negedge clk);
            b_lp = n_lp; b_lk = n_lk; b_st = n_st; b_err = n_err;
            e_lp = 0; e_lk = 0; e_st = 0; e_err = 0;
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                n = (kind == 0) ? 4 : 8;
                abort = ($urandom_range(0, 5) == 0);
                nsend = abort ? int'($urandom_range(0, n - 1)) : n;
                send_byte((kind == 0) ? 8'h50 : 8'h4B);
                v = '0;
                for (int j = 0; j < nsend; j++) begin
                    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 2)) : 0;
                    repeat (gap) @(negedge clk);
                    b = 8'($urandom);
                    send_byte(b);
                    v = {v[55:0], b};
                end
                if (abort) begin
                    idle(TO + 4);
                    e_err = 1;
                end else begin
                    idle(6);
                    if (kind == 0) begin p_m = v[31:0]; e_lp = 1; end
                    else begin k_m = v; e_lk = 1; end
                end
            end else if (kind == 2) begin
                send_byte(8'h53);
                idle(4);
                e_st = 1;
            end else begin
                do b = 8'($urandom); while (b == 8'h50 || b == 8'h4B || b == 8'h53);
                send_byte(b);
                idle(4);
                e_err = 1;
            end
            check($sformatf("rnd%0d_plntxt", it), 64'(bus.plntxt), 64'(p_m));
            check($sformatf("rnd%0d_key", it), bus.key, k_m);
            check($sformatf("rnd%0d_strobes", it),
                  64'({8'(n_lp - b_lp), 8'(n_lk - b_lk), 8'(n_st - b_st), 8'(n_err - b_err)}),
                  64'({8'(e_lp), 8'(e_lk), 8'(e_st), 8'(e_err)}));
            check($sformatf("rnd%0d_busy", it), 64'(bus.busy), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
